// File: rtl/and_64bit_pkg.sv
// Shared constants for the Y86-64 SEQ ALU slice: word width and ALU function codes.
package and_64bit_pkg;

    localparam int unsigned WORD_W = 64;

    // Y86-64 OPq ifun encodings; the AND select drives and_64bit.enable upstream.
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    function automatic logic is_and_op(input logic [3:0] ifun);
        return ifun == ALU_AND;
    endfunction

endpackage

// File: rtl/and_64bit_and_bit.sv
// Single-bit AND cell built from a gate primitive; replicated across the word by and_64bit.
module and_bit (
    input  logic a,
    input  logic b,
    output logic y
);

    and u_and (y, a, b);

endmodule

// File: rtl/and_64bit.sv
// Registered bitwise AND unit; output is zero when disabled so it can be OR-merged with sibling units.
module and_64bit
    import and_64bit_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] Out,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             enable
);

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] gated;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and_bit u_and_bit (
            .a (A[i]),
            .b (B[i]),
            .y (raw[i])
        );
    end

    assign gated = raw & {WIDTH{enable}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Out <= '0;
        end else begin
            Out <= gated;
        end
    end

endmodule

// File: tb/tb_and_64bit.sv
// Directed-table and random checks for the registered 64-bit AND unit.
module tb_and_64bit;

    logic        clk;
    logic        rst;
    logic [63:0] Out;
    logic [63:0] A;
    logic [63:0] B;
    logic        enable;

    int unsigned checks;
    int unsigned errors;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        en;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    and_64bit #(.WIDTH(64)) dut (
        .clk    (clk),
        .rst    (rst),
        .Out    (Out),
        .A      (A),
        .B      (B),
        .enable (enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic        ren;

        checks = 0;
        errors = 0;

        vecs[0] = '{64'h4, 64'h3, 1'b1, 64'h0};
        vecs[1] = '{64'h7, 64'h3, 1'b1, 64'h3};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA};
        vecs[3] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0, 64'h0};
        vecs[4] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b1, 64'h8000_0000_0000_0001};
        vecs[5] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 64'h0};
        vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0};
        vecs[9] = '{64'h0123_4567_89AB_CDEF, 64'hF0F0_F0F0_F0F0_F0F0, 1'b1, 64'h0020_4060_80A0_C0E0};

        // Reset asserted before the first clock edge must clear Out on its own.
        rst    = 1'b0;
        A      = {$urandom, $urandom};
        B      = {$urandom, $urandom};
        enable = 1'b1;
        #2 rst = 1'b1;
        #1 check("async_reset", Out, 64'h0);

        @(posedge clk);
        #1 check("reset_hold_edge", Out, 64'h0);

        @(negedge clk);
        rst = 1'b0;
        #1 check("reset_release_no_edge", Out, 64'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            A      = vecs[i].a;
            B      = vecs[i].b;
            enable = vecs[i].en;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), Out, vecs[i].exp);
        end

        // Out=3 must hold while inputs and enable churn between edges.
        @(negedge clk);
        A = 64'h7; B = 64'h3; enable = 1'b1;
        @(posedge clk);
        #1 check("load_3", Out, 64'h3);
        A = 64'hFFFF_FFFF_FFFF_FFFF;
        B = 64'hFFFF_FFFF_FFFF_FFFF;
        enable = 1'b0;
        #1 enable = 1'b1;
        #1 check("hold_midcycle", Out, 64'h3);
        rst = 1'b1;
        #1 check("reset_midcycle", Out, 64'h0);
        @(negedge clk);
        A = 64'hF0; B = 64'h3C; enable = 1'b1;
        rst = 1'b0;
        #1 check("after_release_before_edge", Out, 64'h0);
        @(posedge clk);
        #1 check("first_capture_after_reset", Out, 64'h30);

        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            ren = 1'($urandom_range(0, 1));
            A = ra; B = rb; enable = ren;
            @(posedge clk);
            #1 check("random", Out, ren ? (ra & rb) : 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
